// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter that shares one single-port memory bus
//               between the instruction-fetch (IF) and load-store (LS) ports.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_req_i,
    input  logic [DATA_WIDTH-1:0] if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    input  logic                  ls_req_i,
    input  logic                  ls_we_i,
    input  logic [DATA_WIDTH-1:0] ls_addr_i,
    input  logic [DATA_WIDTH-1:0] ls_wdata_i,
    output logic                  ls_gnt_o,
    output logic                  ls_rvalid_o,
    output logic [DATA_WIDTH-1:0] ls_rdata_o,
    output logic                  err_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_LS = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_ls;
    logic [15:0]           r_cnt;
    logic                  r_if_rvalid;
    logic                  r_ls_rvalid;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_ls_rdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  w_idle;
    logic                  w_if_gnt;
    logic                  w_ls_gnt;

    // On a tie the requester that did not own the previous transfer wins.
    assign w_idle   = (r_state == S_IDLE);
    assign w_if_gnt = w_idle && if_req_i && (!ls_req_i || r_last_ls);
    assign w_ls_gnt = w_idle && ls_req_i && (!if_req_i || !r_last_ls);

    assign if_gnt_o    = w_if_gnt;
    assign ls_gnt_o    = w_ls_gnt;
    assign if_rvalid_o = r_if_rvalid;
    assign ls_rvalid_o = r_ls_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign ls_rdata_o  = r_ls_rdata;
    assign err_o       = r_err;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_last_ls   <= 1'b0;
            r_cnt       <= '0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_if_gnt) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr_i;
                        r_mem_wdata <= '0;
                        r_last_ls   <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY_IF;
                    end else if (w_ls_gnt) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ls_we_i;
                        r_mem_addr  <= ls_addr_i;
                        r_mem_wdata <= ls_wdata_i;
                        r_last_ls   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_BUSY_LS;
                    end
                end
                S_BUSY_IF, S_BUSY_LS: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_IDLE;
                        if (r_state == S_BUSY_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= mem_rdata_i;
                        end else begin
                            r_ls_rvalid <= 1'b1;
                            r_ls_rdata  <= r_mem_we ? '0 : mem_rdata_i;
                        end
                    end else if (r_cnt == c_TMO_LAST) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_IDLE;
                        if (r_state == S_BUSY_IF) begin
                            r_if_rvalid <= 1'b1;
                            r_if_rdata  <= '0;
                        end else begin
                            r_ls_rvalid <= 1'b1;
                            r_ls_rdata  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a transaction-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          if_req_i = 1'b0;
    logic [DW-1:0] if_addr_i = '0;
    logic          if_gnt_o, if_rvalid_o;
    logic [DW-1:0] if_rdata_o;
    logic          ls_req_i = 1'b0, ls_we_i = 1'b0;
    logic [DW-1:0] ls_addr_i = '0, ls_wdata_i = '0;
    logic          ls_gnt_o, ls_rvalid_o;
    logic [DW-1:0] ls_rdata_o;
    logic          err_o, mem_req_o, mem_we_o;
    logic [DW-1:0] mem_addr_o, mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: owner 0 = none, 1 = IF, 2 = LS; a transfer ends on the
    // first ack or after TMO busy cycles, whichever comes first.
    int            cyc = 0;
    int            m_owner = 0;
    int            m_last = 1;
    int            m_gcyc = 0;
    logic          m_tx_we = 1'b0;
    logic          e_if_gnt, e_ls_gnt;
    logic          e_if_rv = 0, e_ls_rv = 0, e_err = 0;
    logic [DW-1:0] e_if_rd = '0, e_ls_rd = '0;
    logic          e_mreq = 0, e_mwe = 0;
    logic [DW-1:0] e_maddr = '0, e_mwd = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_last = 1;
        e_if_rv = 0; e_ls_rv = 0; e_err = 0;
        e_if_rd = '0; e_ls_rd = '0;
        e_mreq = 0; e_mwe = 0; e_maddr = '0; e_mwd = '0;
    endtask

    task automatic step(input logic ir, input logic [DW-1:0] ia,
                        input logic lr, input logic lw, input logic [DW-1:0] la,
                        input logic [DW-1:0] lwd, input logic ak, input logic [DW-1:0] rd);
        @(negedge clk);
        if_req_i = ir; if_addr_i = ia;
        ls_req_i = lr; ls_we_i = lw; ls_addr_i = la; ls_wdata_i = lwd;
        mem_ack_i = ak; mem_rdata_i = rd;
        e_if_gnt = (m_owner == 0) && ir && (!lr || m_last == 2);
        e_ls_gnt = (m_owner == 0) && lr && (!ir || m_last == 1);
        #1;
        chk("if_gnt", if_gnt_o, e_if_gnt);
        chk("ls_gnt", ls_gnt_o, e_ls_gnt);
        chk("if_rvalid", if_rvalid_o, e_if_rv);
        chk("ls_rvalid", ls_rvalid_o, e_ls_rv);
        chk("if_rdata", if_rdata_o, e_if_rd);
        chk("ls_rdata", ls_rdata_o, e_ls_rd);
        chk("err", err_o, e_err);
        chk("mem_req", mem_req_o, e_mreq);
        chk("mem_we", mem_we_o, e_mwe);
        chk("mem_addr", mem_addr_o, e_maddr);
        chk("mem_wdata", mem_wdata_o, e_mwd);
        e_if_rv = 0; e_ls_rv = 0; e_err = 0;
        if (m_owner != 0) begin
            if (ak || (cyc - m_gcyc) == TMO) begin
                e_mreq = 0;
                if (ak) e_mwe = 0;
                e_err = !ak;
                if (m_owner == 1) begin
                    e_if_rv = 1; e_if_rd = ak ? rd : '0;
                end else begin
                    e_ls_rv = 1; e_ls_rd = (ak && !m_tx_we) ? rd : '0;
                end
                m_owner = 0;
            end
        end else if (e_if_gnt || e_ls_gnt) begin
            m_owner = e_if_gnt ? 1 : 2;
            m_last  = m_owner;
            m_gcyc  = cyc;
            m_tx_we = e_ls_gnt && lw;
            e_mreq  = 1;
            e_mwe   = m_tx_we;
            e_maddr = e_if_gnt ? ia : la;
            e_mwd   = e_if_gnt ? '0 : lwd;
        end
        cyc++;
    endtask

    task automatic do_reset();
        #1;
        if_req_i = 0; ls_req_i = 0; mem_ack_i = 0;
        rst_ni = 0;
        #1;
        model_reset();
        chk("rst_if_gnt", if_gnt_o, 0);
        chk("rst_ls_gnt", ls_gnt_o, 0);
        chk("rst_if_rvalid", if_rvalid_o, 0);
        chk("rst_ls_rvalid", ls_rvalid_o, 0);
        chk("rst_if_rdata", if_rdata_o, 0);
        chk("rst_ls_rdata", ls_rdata_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_we", mem_we_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        @(posedge clk); @(posedge clk);
        #2 rst_ni = 1;
    endtask

    initial begin
        logic          ip, lp, lw, cur_ls;
        logic [DW-1:0] ia, la, lwd;
        int            prev, ngr;

        do_reset();
        // IF-only read with ack on cycle 3
        step(1, 32'h10, 0, 0, 0, 0, 0, 0);               chk("d1_gnt", if_gnt_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d1_req", mem_req_o, 1);
                                                         chk("d1_addr", mem_addr_o, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h0051_3093);
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d1_rvalid", if_rvalid_o, 1);
                                                         chk("d1_rdata", if_rdata_o, 32'h0051_3093);
                                                         chk("d1_err", err_o, 0);

        // Tie after reset: LS write first, IF granted in the LS rvalid cycle
        do_reset();
        step(1, 32'h20, 1, 1, 32'h7000, 32'hA5A5_A5A5, 0, 0);
        chk("d2_ls_gnt", ls_gnt_o, 1);                   chk("d2_if_gnt0", if_gnt_o, 0);
        step(1, 32'h20, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);   chk("d2_we", mem_we_o, 1);
        chk("d2_wdata", mem_wdata_o, 32'hA5A5_A5A5);     chk("d2_addr", mem_addr_o, 32'h7000);
        step(1, 32'h20, 0, 0, 0, 0, 0, 0);               chk("d2_ls_rv", ls_rvalid_o, 1);
        chk("d2_ls_rd", ls_rdata_o, 0);                  chk("d2_if_gnt", if_gnt_o, 1);
        step(0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);        chk("d2_if_addr", mem_addr_o, 32'h20);
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d2_if_rd", if_rdata_o, 32'hCAFE_F00D);

        // Sustained contention must alternate LS, IF, LS, ...
        do_reset();
        prev = 0; ngr = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, $urandom, 1, 1'($urandom), $urandom, $urandom, 1, $urandom);
            if (if_gnt_o || ls_gnt_o) begin
                cur_ls = ls_gnt_o;
                if (prev == 0) chk("d3_first_ls", cur_ls, 1);
                else           chk("d3_alternate", (cur_ls ? 2 : 1) != prev, 1);
                prev = cur_ls ? 2 : 1;
                ngr++;
            end
        end
        chk("d3_grants", ngr, 8);

        // Timeout: LS read, memory silent
        do_reset();
        step(0, 0, 1, 0, 32'h300, 0, 0, 0);              chk("d4_gnt", ls_gnt_o, 1);
        for (int k = 1; k <= TMO; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);                chk("d4_req_hi", mem_req_o, 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d4_rvalid", ls_rvalid_o, 1);
        chk("d4_err", err_o, 1);                         chk("d4_rdata", ls_rdata_o, 0);
        chk("d4_req_lo", mem_req_o, 0);

        // Ack on the last allowed busy cycle wins over the timeout
        step(0, 0, 1, 0, 32'h304, 0, 0, 0);              chk("d5_gnt", ls_gnt_o, 1);
        for (int k = 1; k < TMO; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 32'h1234);
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d5_rvalid", ls_rvalid_o, 1);
        chk("d5_rdata", ls_rdata_o, 32'h1234);           chk("d5_err", err_o, 0);

        // Reset while IF is busy: silent abort, then LS wins the tie
        do_reset();
        step(1, 32'h40, 0, 0, 0, 0, 0, 0);               chk("d6_gnt", if_gnt_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d6_busy", mem_req_o, 1);
        do_reset();
        step(1, 32'h44, 1, 0, 32'h48, 0, 0, 0);          chk("d6_ls_tie", ls_gnt_o, 1);
        step(0, 0, 0, 0, 0, 0, 1, 32'h55);
        step(0, 0, 0, 0, 0, 0, 0, 0);                    chk("d6_no_if_rv", if_rvalid_o, 0);

        // Random traffic: requesters hold their request until granted
        ip = 0; lp = 0; lw = 0; ia = '0; la = '0; lwd = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin ip = 1; ia = $urandom; end
            if (!lp && $urandom_range(0, 2) == 0) begin
                lp = 1; lw = 1'($urandom); la = $urandom; lwd = $urandom;
            end
            step(ip, ia, lp, lw, la, lwd, $urandom_range(0, 9) < 3, $urandom);
            if (e_if_gnt) ip = 0;
            if (e_ls_gnt) lp = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
